ooo_age_scheduler: RTL and testbench

- Out-of-order, age-prioritised uop scheduler placed between the despatch unit and one execution unit.
- Holds up to SLOTS uops and captures operand readiness from the scoreboard at insert.
- Wakes operands from writeback broadcasts and issues the oldest fully-ready uop.
- Output register honours the execution-unit stall, so uops are never dropped; a flush empties the block.

---
 rtl/ooo_age_scheduler_pkg.sv | 30 +++
 rtl/sched_age_matrix.sv | 56 +++++
 rtl/ooo_age_scheduler.sv | 176 +++++++++++++++++
 tb/tb_ooo_age_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_age_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ooo_age_scheduler_pkg
// Description : Shared types and constants for the age-ordered uop scheduler.
//               Defines the micro-op layout (with per-operand "used" flags)
//               and a helper that extracts a source operand's PR index.
// Revision    : 1.0 - initial release
// ============================================================================
package ooo_age_scheduler_pkg;

    localparam int SCHED_DEFAULT_SLOTS = 8;
    localparam int c_num_pr            = 64;
    localparam int c_rd_oprnds         = 2;
    localparam int c_pr_w              = $clog2(c_num_pr);
    localparam int c_opc_w             = 8;

    typedef struct packed {
        logic [c_opc_w-1:0]                   opcode;
        logic [c_pr_w-1:0]                    dst_pr;
        logic [c_rd_oprnds-1:0][c_pr_w-1:0]   src_pr;
        logic [c_rd_oprnds-1:0]               src_used;
    } micro_op_t;

    // Physical register index of source operand j.
    function automatic logic [c_pr_w-1:0] sched_src_pr(input micro_op_t uop, input int j);
        return uop.src_pr[j];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sched_age_matrix.sv
`default_nettype none
// ============================================================================
// Module      : sched_age_matrix
// Description : Relative-age matrix for SLOTS scheduler entries and the
//               oldest-requester select. r_age[i][j]=1 means slot i is older
//               than slot j.
// Ports       : i_clk, i_rst (sync, active-low), i_flush   - control
//               i_ins / i_ins_onehot                       - slot being filled
//               i_valid                                    - registered slot valid
//               i_req                                      - ready candidates
//               o_grant                                    - one-hot oldest candidate
// Revision    : 1.0 - initial release
// ============================================================================
module sched_age_matrix #(
    parameter int SLOTS = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_ins,
    input  logic [SLOTS-1:0] i_ins_onehot,
    input  logic [SLOTS-1:0] i_valid,
    input  logic [SLOTS-1:0] i_req,
    output logic [SLOTS-1:0] o_grant
);

    logic [SLOTS-1:0] r_age [SLOTS];

    // Rows of invalid slots may hold stale bits; they are never consulted
    // because the select only looks at requesting (hence valid) slots, and a
    // slot's row is cleared when it is refilled.
    always_ff @(posedge i_clk) begin
        if (!i_rst || i_flush) begin
            for (int i = 0; i < SLOTS; i++) r_age[i] <= '0;
        end else if (i_ins) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (i_ins_onehot[i])
                    r_age[i] <= '0;
                else if (i_valid[i])
                    r_age[i] <= r_age[i] | i_ins_onehot;
            end
        end
    end

    for (genvar i = 0; i < SLOTS; i++) begin : g_grant
        logic w_older_req;
        always_comb begin
            w_older_req = 1'b0;
            for (int j = 0; j < SLOTS; j++)
                if (i_req[j] && r_age[j][i]) w_older_req = 1'b1;
        end
        assign o_grant[i] = i_req[i] & ~w_older_req;
    end

endmodule
`default_nettype wire

// File: rtl/ooo_age_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ooo_age_scheduler
// Description : Out-of-order, age-prioritised uop scheduler between despatch
//               and one execution unit. Captures operand readiness at insert,
//               wakes operands from writeback broadcasts (with same-cycle
//               bypass) and issues the oldest fully-ready uop into a
//               stall-aware output register.
// Ports       : i_clk, i_rst (sync, active-low), i_flush
//               i_inp_uop_p/i_inp_uop      - despatch input
//               o_sched_full/o_free_slots  - occupancy (registered state only)
//               i_pr_valid                 - scoreboard valid bits
//               i_wb_p/i_wb_pr             - writeback broadcasts
//               o_exec_unit_uop_p/o_exec_unit_uop, i_exec_unit_stall - issue
// Revision    : 1.0 - initial release
// ============================================================================
module ooo_age_scheduler
    import ooo_age_scheduler_pkg::*;
#(
    parameter int SLOTS             = SCHED_DEFAULT_SLOTS,
    parameter int NUM_PHYSICAL_REGS = c_num_pr,
    parameter int RD_OPRNDS         = c_rd_oprnds,
    parameter int WB_PORTS          = 2,
    parameter int PR_W              = $clog2(NUM_PHYSICAL_REGS)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_flush,
    input  logic                         i_inp_uop_p,
    input  micro_op_t                    i_inp_uop,
    output logic                         o_sched_full,
    output logic [$clog2(SLOTS):0]       o_free_slots,
    input  logic [NUM_PHYSICAL_REGS-1:0] i_pr_valid,
    input  logic [WB_PORTS-1:0]          i_wb_p,
    input  logic [WB_PORTS*PR_W-1:0]     i_wb_pr,
    output logic                         o_exec_unit_uop_p,
    input  logic                         i_exec_unit_stall,
    output micro_op_t                    o_exec_unit_uop
);

    localparam int c_cnt_w = $clog2(SLOTS) + 1;

    logic [SLOTS-1:0]     r_valid;
    micro_op_t            r_uop [SLOTS];
    logic [RD_OPRNDS-1:0] r_rdy [SLOTS];
    logic                 r_out_p;
    micro_op_t            r_out_uop;

    logic [RD_OPRNDS-1:0] w_wake [SLOTS];
    logic [RD_OPRNDS-1:0] w_ins_rdy;
    logic [SLOTS-1:0]     w_req;
    logic [SLOTS-1:0]     w_grant;
    logic [SLOTS-1:0]     w_ins_sel;
    logic [c_cnt_w-1:0]   w_free_cnt;
    logic                 w_ins;
    logic                 w_issue;
    micro_op_t            w_issue_uop;

    function automatic logic wb_hit(input logic [PR_W-1:0]          pr,
                                    input logic [WB_PORTS-1:0]      wb_p,
                                    input logic [WB_PORTS*PR_W-1:0] wb_pr);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < WB_PORTS; k++)
            if (wb_p[k] && (wb_pr[k*PR_W +: PR_W] == pr)) hit = 1'b1;
        return hit;
    endfunction

    // Occupancy comes from registered valids only, so an issue this cycle
    // never makes room for an insert this cycle.
    always_comb begin
        w_free_cnt = '0;
        for (int i = 0; i < SLOTS; i++)
            w_free_cnt = w_free_cnt + c_cnt_w'(~r_valid[i]);
    end

    assign o_sched_full = &r_valid;
    assign o_free_slots = w_free_cnt;

    // Lowest-index free slot.
    always_comb begin
        logic found;
        found     = 1'b0;
        w_ins_sel = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!r_valid[i] && !found) begin
                w_ins_sel[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign w_ins = i_inp_uop_p & ~o_sched_full & ~i_flush;

    for (genvar j = 0; j < RD_OPRNDS; j++) begin : g_ins_op
        assign w_ins_rdy[j] = ~i_inp_uop.src_used[j]
                            | i_pr_valid[sched_src_pr(i_inp_uop, j)]
                            | wb_hit(sched_src_pr(i_inp_uop, j), i_wb_p, i_wb_pr);
    end

    // w_wake doubles as the wakeup update and the same-cycle bypass term.
    for (genvar s = 0; s < SLOTS; s++) begin : g_slot
        for (genvar j = 0; j < RD_OPRNDS; j++) begin : g_op
            assign w_wake[s][j] = r_valid[s] & wb_hit(sched_src_pr(r_uop[s], j), i_wb_p, i_wb_pr);
        end
        assign w_req[s] = r_valid[s] & (&(r_rdy[s] | w_wake[s]));
    end

    sched_age_matrix #(
        .SLOTS (SLOTS)
    ) u_age (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_flush      (i_flush),
        .i_ins        (w_ins),
        .i_ins_onehot (w_ins_sel),
        .i_valid      (r_valid),
        .i_req        (w_req),
        .o_grant      (w_grant)
    );

    assign w_issue = (|w_req) & (~r_out_p | ~i_exec_unit_stall);

    always_comb begin
        w_issue_uop = '0;
        for (int i = 0; i < SLOTS; i++)
            if (w_grant[i]) w_issue_uop = r_uop[i];
    end

    // Slot valid / readiness state. The issuing slot and the inserted slot
    // are always distinct because insert only targets registered-free slots.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_valid <= '0;
            for (int i = 0; i < SLOTS; i++) r_rdy[i] <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (w_issue && w_grant[i]) begin
                    r_valid[i] <= 1'b0;
                end else if (w_ins && w_ins_sel[i]) begin
                    r_valid[i] <= 1'b1;
                    r_rdy[i]   <= w_ins_rdy;
                end else if (r_valid[i]) begin
                    r_rdy[i]   <= r_rdy[i] | w_wake[i];
                end
            end
        end
    end

    // Payload storage needs no reset; it is qualified by r_valid.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < SLOTS; i++)
            if (w_ins && w_ins_sel[i]) r_uop[i] <= i_inp_uop;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_out_p   <= 1'b0;
            r_out_uop <= '0;
        end else if (i_flush) begin
            r_out_p   <= 1'b0;
        end else if (w_issue) begin
            r_out_p   <= 1'b1;
            r_out_uop <= w_issue_uop;
        end else if (!i_exec_unit_stall) begin
            r_out_p   <= 1'b0;
        end
    end

    assign o_exec_unit_uop_p = r_out_p;
    assign o_exec_unit_uop   = r_out_uop;

endmodule
`default_nettype wire

// File: tb/tb_ooo_age_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ooo_age_scheduler
// Description : Directed self-checking bench for ooo_age_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ooo_age_scheduler;
    import ooo_age_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        inp_p = 1'b0;
    micro_op_t   inp_uop = '0;
    logic        full;
    logic [3:0]  free;
    logic [63:0] pr_valid = '1;
    logic [1:0]  wb_p = '0;
    logic [11:0] wb_pr = '0;
    logic        out_p;
    logic        stall = 1'b0;
    micro_op_t   out_uop;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ooo_age_scheduler dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_flush           (flush),
        .i_inp_uop_p       (inp_p),
        .i_inp_uop         (inp_uop),
        .o_sched_full      (full),
        .o_free_slots      (free),
        .i_pr_valid        (pr_valid),
        .i_wb_p            (wb_p),
        .i_wb_pr           (wb_pr),
        .o_exec_unit_uop_p (out_p),
        .i_exec_unit_stall (stall),
        .o_exec_unit_uop   (out_uop)
    );

    // Despatch must never present a uop while the scheduler is full.
    always @(posedge clk) begin
        if (rst && inp_p && full) begin
            n_fail++;
            $display("FAIL insert_while_full: got inp_p=1 with full=1 want no insert");
        end
    end

    function automatic micro_op_t mk(input logic [7:0] opc, input logic [5:0] s0, input logic u0,
                                     input logic [5:0] s1, input logic u1);
        micro_op_t m;
        m.opcode    = opc;
        m.dst_pr    = opc[5:0];
        m.src_pr[0] = s0;
        m.src_pr[1] = s1;
        m.src_used  = {u1, u0};
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        inp_p = 1'b1; inp_uop = mk(8'h55, 6'd1, 1'b1, 6'd2, 1'b1);
        step(); step();
        n_tests++; if (out_p !== 1'b0) begin n_fail++; $display("FAIL reset_out_p: got %b want 0", out_p); end
        n_tests++; if (out_uop !== micro_op_t'(0)) begin n_fail++; $display("FAIL reset_out_uop: got %h want 0", out_uop); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_tests++; if (free !== 4'd8) begin n_fail++; $display("FAIL reset_free: got %0d want 8", free); end
        inp_p = 1'b0;
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        micro_op_t a;
        a = mk(8'h11, 6'd1, 1'b1, 6'd2, 1'b1);
        pr_valid = '1;
        inp_p = 1'b1; inp_uop = a;
        step();
        inp_p = 1'b0;
        n_tests++; if (free !== 4'd7) begin n_fail++; $display("FAIL basic_free_after_insert: got %0d want 7", free); end
        n_tests++; if (out_p !== 1'b0) begin n_fail++; $display("FAIL basic_latency_edge1: got %b want 0", out_p); end
        step();
        n_tests++; if (out_p !== 1'b1 || out_uop !== a) begin n_fail++; $display("FAIL basic_issue: got p=%b uop=%h want p=1 uop=%h", out_p, out_uop, a); end
        n_tests++; if (free !== 4'd8) begin n_fail++; $display("FAIL basic_free_after_issue: got %0d want 8", free); end
        step();
        n_tests++; if (out_p !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b want 0", out_p); end
    endtask

    task automatic test_wakeup();
        micro_op_t a, b;
        a = mk(8'hA1, 6'd5, 1'b1, 6'd0, 1'b0);
        b = mk(8'hB1, 6'd1, 1'b1, 6'd2, 1'b1);
        pr_valid = ~(64'd1 << 5);
        inp_p = 1'b1; inp_uop = a; step();
        inp_uop = b; step();
        inp_p = 1'b0;
        n_tests++; if (free !== 4'd6 || out_p !== 1'b0) begin n_fail++; $display("FAIL wake_hold: got free=%0d p=%b want free=6 p=0", free, out_p); end
        step();
        n_tests++; if (out_p !== 1'b1 || out_uop !== b) begin n_fail++; $display("FAIL wake_b_first: got p=%b uop=%h want p=1 uop=%h", out_p, out_uop, b); end
        wb_p = 2'b01; wb_pr = {6'd0, 6'd5};
        step();
        wb_p = 2'b00;
        n_tests++; if (out_p !== 1'b1 || out_uop !== a) begin n_fail++; $display("FAIL wake_a_bypass: got p=%b uop=%h want p=1 uop=%h", out_p, out_uop, a); end
        step();
        n_tests++; if (out_p !== 1'b0 || free !== 4'd8) begin n_fail++; $display("FAIL wake_drain: got p=%b free=%0d want p=0 free=8", out_p, free); end
    endtask

    task automatic test_age_order();
        micro_op_t a, b;
        a = mk(8'hC1, 6'd9, 1'b1, 6'd0, 1'b0);
        b = mk(8'hC2, 6'd3, 1'b1, 6'd9, 1'b1);
        pr_valid = ~(64'd1 << 9);
        inp_p = 1'b1; inp_uop = a; step();
        inp_uop = b; step();
        inp_p = 1'b0;
        wb_p = 2'b10; wb_pr = {6'd9, 6'd0};
        step();
        wb_p = 2'b00;
        n_tests++; if (out_p !== 1'b1 || out_uop !== a) begin n_fail++; $display("FAIL age_oldest_first: got p=%b uop=%h want p=1 uop=%h", out_p, out_uop, a); end
        step();
        n_tests++; if (out_p !== 1'b1 || out_uop !== b) begin n_fail++; $display("FAIL age_stored_wake: got p=%b uop=%h want p=1 uop=%h", out_p, out_uop, b); end
        step();
        n_tests++; if (out_p !== 1'b0 || free !== 4'd8) begin n_fail++; $display("FAIL age_drain: got p=%b free=%0d want p=0 free=8", out_p, free); end
    endtask

    task automatic test_full();
        pr_valid = ~(64'hFF << 20);
        inp_p = 1'b1;
        for (int i = 0; i < 8; i++) begin
            inp_uop = mk(8'h30 + 8'(i), 6'd20 + 6'(i), 1'b1, 6'd0, 1'b0);
            step();
        end
        inp_p = 1'b0;
        n_tests++; if (full !== 1'b1 || free !== 4'd0) begin n_fail++; $display("FAIL full_set: got full=%b free=%0d want full=1 free=0", full, free); end
        n_tests++; if (out_p !== 1'b0) begin n_fail++; $display("FAIL full_no_issue: got %b want 0", out_p); end
        wb_p = 2'b01; wb_pr = {6'd0, 6'd23};
        step();
        wb_p = 2'b00;
        n_tests++; if (full !== 1'b0 || free !== 4'd1) begin n_fail++; $display("FAIL full_clear: got full=%b free=%0d want full=0 free=1", full, free); end
        n_tests++; if (out_p !== 1'b1 || out_uop.opcode !== 8'h33) begin n_fail++; $display("FAIL full_issue_slot3: got p=%b opc=%h want p=1 opc=33", out_p, out_uop.opcode); end
        flush = 1'b1; step(); flush = 1'b0;
        n_tests++; if (free !== 4'd8 || out_p !== 1'b0) begin n_fail++; $display("FAIL full_flush: got free=%0d p=%b want free=8 p=0", free, out_p); end
    endtask

    task automatic test_stall();
        micro_op_t c, d;
        c = mk(8'hD1, 6'd1, 1'b1, 6'd2, 1'b0);
        d = mk(8'hD2, 6'd3, 1'b1, 6'd4, 1'b1);
        pr_valid = '1;
        inp_p = 1'b1; inp_uop = c; step();
        inp_uop = d; step();
        inp_p = 1'b0;
        n_tests++; if (out_p !== 1'b1 || out_uop !== c) begin n_fail++; $display("FAIL stall_c_out: got p=%b uop=%h want p=1 uop=%h", out_p, out_uop, c); end
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++; if (out_p !== 1'b1 || out_uop !== c) begin n_fail++; $display("FAIL stall_hold%0d: got p=%b uop=%h want p=1 uop=%h", k, out_p, out_uop, c); end
        end
        stall = 1'b0;
        step();
        n_tests++; if (out_p !== 1'b1 || out_uop !== d) begin n_fail++; $display("FAIL stall_release_d: got p=%b uop=%h want p=1 uop=%h", out_p, out_uop, d); end
        step();
        n_tests++; if (out_p !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %b want 0", out_p); end
    endtask

    task automatic test_back_to_back();
        micro_op_t u [3];
        for (int i = 0; i < 3; i++) u[i] = mk(8'h70 + 8'(i), 6'(i), 1'b1, 6'd10, 1'b1);
        pr_valid = '1;
        inp_p = 1'b1; inp_uop = u[0]; step();
        for (int i = 1; i < 4; i++) begin
            if (i < 3) inp_uop = u[i]; else inp_p = 1'b0;
            step();
            n_tests++; if (out_p !== 1'b1 || out_uop !== u[i-1]) begin n_fail++; $display("FAIL b2b_%0d: got p=%b uop=%h want p=1 uop=%h", i-1, out_p, out_uop, u[i-1]); end
        end
        step();
        n_tests++; if (out_p !== 1'b0 || free !== 4'd8) begin n_fail++; $display("FAIL b2b_drain: got p=%b free=%0d want p=0 free=8", out_p, free); end
    endtask

    task automatic test_flush();
        micro_op_t r;
        r = mk(8'hE0, 6'd1, 1'b1, 6'd2, 1'b1);
        pr_valid = ~(64'd1 << 40);
        inp_p = 1'b1; inp_uop = r; step();
        for (int i = 0; i < 5; i++) begin
            inp_uop = mk(8'hE1 + 8'(i), 6'd40, 1'b1, 6'd0, 1'b0);
            step();
            stall = 1'b1;
        end
        n_tests++; if (free !== 4'd3 || out_p !== 1'b1 || out_uop !== r) begin n_fail++; $display("FAIL flush_setup: got free=%0d p=%b uop=%h want free=3 p=1 uop=%h", free, out_p, out_uop, r); end
        flush = 1'b1;
        inp_uop = mk(8'hEF, 6'd1, 1'b1, 6'd2, 1'b0);
        step();
        n_tests++; if (out_p !== 1'b0 || free !== 4'd8 || full !== 1'b0) begin n_fail++; $display("FAIL flush_clear: got p=%b free=%0d full=%b want p=0 free=8 full=0", out_p, free, full); end
        flush = 1'b0; inp_p = 1'b0; stall = 1'b0;
        step();
        n_tests++; if (out_p !== 1'b0 || free !== 4'd8) begin n_fail++; $display("FAIL flush_insert_dropped: got p=%b free=%0d want p=0 free=8", out_p, free); end
    endtask

    task automatic test_reset_mid_stall();
        pr_valid = '1;
        inp_p = 1'b1; inp_uop = mk(8'hF1, 6'd1, 1'b1, 6'd2, 1'b1); step();
        inp_uop = mk(8'hF2, 6'd3, 1'b1, 6'd4, 1'b1); step();
        inp_p = 1'b0; stall = 1'b1;
        step();
        n_tests++; if (out_p !== 1'b1 || out_uop.opcode !== 8'hF1) begin n_fail++; $display("FAIL rst_setup: got p=%b opc=%h want p=1 opc=F1", out_p, out_uop.opcode); end
        rst = 1'b0;
        step();
        n_tests++; if (out_p !== 1'b0 || out_uop !== micro_op_t'(0)) begin n_fail++; $display("FAIL rst_mid_out: got p=%b uop=%h want p=0 uop=0", out_p, out_uop); end
        n_tests++; if (free !== 4'd8 || full !== 1'b0) begin n_fail++; $display("FAIL rst_mid_occ: got free=%0d full=%b want free=8 full=0", free, full); end
        rst = 1'b1; stall = 1'b0;
        step();
        n_tests++; if (out_p !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flushed: got %b want 0", out_p); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_age_order();
        test_full();
        test_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
